// File: rtl/slow_window_pkg.sv
// slow_window_pkg: state encoding, reset constants and the slow-device bit order
// shared by the slow-window block and the configuration register block.
package slow_window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COUNT  = 2'd2
  } state_e;

  localparam int SLOW_DEV_N = 6;

  // Device vectors are always packed {IACK,VIA,IWM,SCC,SCSI,Snd}, MSB first
  localparam int DEV_IACK = 5;
  localparam int DEV_VIA  = 4;
  localparam int DEV_IWM  = 3;
  localparam int DEV_SCC  = 2;
  localparam int DEV_SCSI = 1;
  localparam int DEV_SND  = 0;

  localparam logic [3:0] CNT_RST = 4'd0;
  localparam logic       OUT_RST = 1'b0;

  typedef logic [SLOW_DEV_N-1:0] dev_vec_t;

  function automatic logic slow_hit(input logic start, input dev_vec_t cs, input dev_vec_t en);
    return start & (|(cs & en));
  endfunction

endpackage

// File: rtl/slow_prescaler.sv
// slow_prescaler: divides CLK by PRESCALE into a one-cycle tick while enabled;
// clear holds the count at zero so each tail starts on a full tick period.
module slow_prescaler #(
  parameter  int PRESCALE = 16,
  localparam int PW       = $clog2(PRESCALE)
) (
  input  logic CLK,
  input  logic nPOR,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  logic [PW-1:0] r_presc;

  assign o_tick = i_enable & (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) r_presc <= '0;
    else if (i_clear || o_tick) r_presc <= '0;
    else if (i_enable) r_presc <= r_presc + 1'b1;
  end

endmodule

// File: rtl/slow_window.sv
// slow_window: opens a slow window on accesses to slow-enabled devices and holds
// SlowMode for the access plus a (T+1)*PRESCALE-cycle tail.
module slow_window
  import slow_window_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       SlowMode,
  output logic       SlowStart,
  output logic       ClockGateReq
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_cnt;
  logic       r_bactr;
  dev_vec_t   w_cs;
  dev_vec_t   w_en;
  logic       w_hit;
  logic       w_tick;
  logic       w_open;

  assign w_cs  = {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS};
  assign w_en  = {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd};
  assign w_hit = slow_hit(BACT & ~r_bactr, w_cs, w_en);

  // A hit in COUNT suppresses the prescaler so it cannot also retire the window
  slow_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .CLK      (CLK),
    .nPOR     (nPOR),
    .i_clear  (r_state != COUNT),
    .i_enable (r_state == COUNT && !w_hit),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_next = (r_state == IDLE)   ? (w_hit ? ACTIVE : IDLE) :
             (r_state == ACTIVE) ? (BACT ? ACTIVE : COUNT) :
             (r_state == COUNT)  ? (w_hit ? ACTIVE : (w_tick && r_cnt == 4'd0) ? IDLE : COUNT) :
             IDLE;
    w_open = (w_next == ACTIVE) && (r_state != ACTIVE);
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      r_state      <= IDLE;
      r_cnt        <= CNT_RST;
      r_bactr      <= 1'b0;
      SlowMode     <= OUT_RST;
      SlowStart    <= OUT_RST;
      ClockGateReq <= OUT_RST;
    end else begin
      r_state      <= w_next;
      r_bactr      <= BACT;
      if (w_open) r_cnt <= SlowTimeout;
      else if (r_state == COUNT && w_tick && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      SlowMode     <= w_next != IDLE;
      SlowStart    <= w_open;
      ClockGateReq <= (w_next != IDLE) && SlowClockGate;
    end
  end

endmodule

// File: tb/tb_slow_window.sv
// tb_slow_window: directed scenarios plus random accesses, checked every cycle
// against a cycle-countdown model of the slow window.
module tb_slow_window;

  localparam int P = 4;

  logic       CLK = 1'b0;
  logic       nPOR = 1'b0;
  logic       BACT = 1'b0;
  logic [5:0] cs = '0;
  logic [5:0] en = '0;
  logic       SlowClockGate = 1'b0;
  logic [3:0] SlowTimeout = 4'd0;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowMode, SlowStart, ClockGateReq;

  int nvec = 0;
  int miscompares = 0;

  assign {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS}       = cs;
  assign {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = en;

  localparam logic [5:0] D_VIA = 6'b010000;
  localparam logic [5:0] D_IWM = 6'b001000;
  localparam logic [5:0] D_SCC = 6'b000100;

  slow_window #(.PRESCALE(P)) dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
    .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS), .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS),
    .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
    .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd),
    .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout),
    .SlowMode(SlowMode), .SlowStart(SlowStart), .ClockGateReq(ClockGateReq)
  );

  always #5 CLK = ~CLK;

  // Model: window open flag, access-in-progress flag, remaining tail cycles
  logic m_mode = 0, m_start = 0, m_gate = 0, m_acc = 0, m_prev = 0, m_hit = 0;
  int   m_tail = 0, m_T = 0;

  always @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      m_mode = 0; m_start = 0; m_gate = 0; m_acc = 0; m_prev = 0; m_tail = 0;
    end else begin
      m_hit = BACT && !m_prev && (|(cs & en));
      m_start = 0;
      if (m_hit && !(m_mode && m_acc)) begin
        m_mode = 1; m_acc = 1; m_T = int'(SlowTimeout); m_start = 1;
      end else if (m_mode && m_acc) begin
        if (!BACT) begin m_acc = 0; m_tail = (m_T + 1) * P; end
      end else if (m_mode) begin
        m_tail--;
        if (m_tail == 0) m_mode = 0;
      end
      m_gate = m_mode && SlowClockGate;
      m_prev = BACT;
    end
  end

  always @(negedge CLK) begin
    nvec++;
    if ({SlowMode, SlowStart, ClockGateReq} !== {m_mode, m_start, m_gate}) begin
      miscompares++;
      $display("FAIL cycle @%0t: {mode,start,gate} got %b%b%b expected %b%b%b",
               $time, SlowMode, SlowStart, ClockGateReq, m_mode, m_start, m_gate);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic access(input logic [5:0] c, input int len, output logic st);
    cs = c; BACT = 1'b1; st = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      if (i == 0) st = SlowStart;
    end
    BACT = 1'b0; cs = '0;
  endtask

  task automatic tail_len(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!SlowMode) return;
      n++;
    end
  endtask

  task automatic reset_pulse(input string name);
    #2 nPOR = 1'b0;
    #1 chk({name, "_async"}, int'({SlowMode, SlowStart, ClockGateReq}), 0);
    @(negedge CLK);
    nPOR = 1'b1;
  endtask

  initial begin
    logic st;
    int n, lows, len, gap, pick;
    // Reset with an access pending on the inputs
    BACT = 1'b1; cs = D_VIA; en = D_VIA;
    repeat (2) @(negedge CLK);
    chk("reset_out", int'({SlowMode, SlowStart, ClockGateReq}), 0);
    BACT = 1'b0; cs = '0; nPOR = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_reset_idle", int'({SlowMode, SlowStart, ClockGateReq}), 0);
    // Basic window, T=3
    SlowTimeout = 4'd3;
    access(D_VIA, 5, st);
    chk("basic_start", int'(st), 1);
    tail_len(n);
    chk("basic_tail", n, 16);
    // Disabled device, then enabled
    repeat (3) @(negedge CLK);
    access(D_SCC, 4, st);
    chk("scc_off_start", int'(st), 0);
    tail_len(n);
    chk("scc_off_mode", n, 0);
    en = D_VIA | D_SCC;
    repeat (2) @(negedge CLK);
    access(D_SCC, 4, st);
    chk("scc_on_start", int'(st), 1);
    tail_len(n);
    chk("scc_on_tail", n, 16);
    // Reload 6 cycles into a T=3 tail with T changed to 1; later T change ignored
    en = D_IWM;
    repeat (2) @(negedge CLK);
    access(D_IWM, 3, st);
    repeat (6) @(negedge CLK);
    chk("reload_open", int'(SlowMode), 1);
    SlowTimeout = 4'd1;
    access(D_IWM, 3, st);
    chk("reload_start", int'(st), 1);
    SlowTimeout = 4'd7;
    tail_len(n);
    chk("reload_tail", n, 8);
    // T=0 with clock gate
    en = D_VIA; SlowTimeout = 4'd0; SlowClockGate = 1'b1;
    repeat (2) @(negedge CLK);
    access(D_VIA, 2, st);
    chk("gate_cgr", int'(ClockGateReq), 1);
    tail_len(n);
    chk("t0_tail", n, 4);
    access(D_VIA, 2, st);
    @(negedge CLK);
    SlowClockGate = 1'b0;
    @(negedge CLK);
    chk("gate_drop_cgr", int'(ClockGateReq), 0);
    chk("gate_drop_mode", int'(SlowMode), 1);
    tail_len(n);
    chk("gate_drop_rest", n, 2);
    // Reset mid-tail; window must not resume
    SlowTimeout = 4'd3; SlowClockGate = 1'b1;
    access(D_VIA, 2, st);
    repeat (3) @(negedge CLK);
    reset_pulse("midtail");
    repeat (5) @(negedge CLK);
    chk("midtail_stays_off", int'(SlowMode), 0);
    // Hit on the final tick of a T=0 tail
    SlowTimeout = 4'd0;
    access(D_VIA, 2, st);
    repeat (4) @(negedge CLK);
    BACT = 1'b1; cs = D_VIA;
    @(negedge CLK);
    chk("coll_start", int'(SlowStart), 1);
    chk("coll_mode", int'(SlowMode), 1);
    lows = 0;
    repeat (30) begin
      @(negedge CLK);
      if (!SlowMode) lows++;
    end
    chk("coll_hold", lows, 0);
    BACT = 1'b0; cs = '0;
    tail_len(n);
    chk("coll_tail", n, 4);
    // Random accesses
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) == 0) en = 6'($urandom_range(0, 63));
      SlowTimeout = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      SlowClockGate = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 7);
      len = $urandom_range(1, 6);
      gap = $urandom_range(1, 40);
      access((pick < 6) ? 6'(1 << pick) : (pick == 6) ? 6'd0 : 6'($urandom_range(0, 63)), len, st);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 9) == 0) SlowClockGate = ~SlowClockGate;
        if ($urandom_range(0, 9) == 0) SlowTimeout = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 199) == 0) reset_pulse("rand");
        else @(negedge CLK);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
